// File: rtl/cf_fft_1024_8_mux_sched.sv
// Stage/bank sequencer for the 1024-point FFT 4:1 bank-select mux: walks every stage per frame.
// Optional build macro CF_FFT_SCHED_ROTATE_EN rotates the bank select by one per stage.
module cf_fft_1024_8_mux_sched #(
    parameter int LOG_POINTS = 10,
    parameter int NUM_STAGES = 10,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  clock_c,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  sync_i,
    output logic [1:0]            sel_o,
    output logic [LOG_POINTS-3:0] addr_o,
    output logic [3:0]            stage_o,
    output logic                  valid_o,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            dbg_state
);

    localparam logic [3:0] LAST_STAGE = 4'(NUM_STAGES - 1);
    localparam logic [7:0] GAP_LAST   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [LOG_POINTS-1:0] cnt, cnt_nxt;
    logic [3:0]            stage, stage_nxt;
    logic [7:0]            gcnt, gcnt_nxt;
    logic                  cnt_last;
    logic                  run;
    logic [1:0]            bank;

    assign cnt_last = (cnt == {LOG_POINTS{1'b1}});
    assign run      = (state == RUN);

    // Disabled cycles freeze every register; reset overrides enable.
    always_ff @(posedge clock_c) begin
        if (reset_i) begin
            state <= IDLE;
            cnt   <= '0;
            stage <= '0;
            gcnt  <= '0;
        end else if (enable_i) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            stage <= stage_nxt;
            gcnt  <= gcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stage_nxt = stage;
        gcnt_nxt  = gcnt;
        case (state)
            IDLE: begin
                if (sync_i) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    stage_nxt = '0;
                    gcnt_nxt  = '0;
                end
            end
            RUN: begin
                // cnt wraps to zero naturally on the stage's last sample.
                cnt_nxt = cnt + 1'b1;
                if (cnt_last) begin
                    if (stage == LAST_STAGE) begin
                        state_nxt = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_nxt = GAP;
                        gcnt_nxt  = '0;
                    end else begin
                        stage_nxt = stage + 1'b1;
                    end
                end
            end
            GAP: begin
                gcnt_nxt = gcnt + 1'b1;
                if (gcnt == GAP_LAST) begin
                    state_nxt = RUN;
                    stage_nxt = stage + 1'b1;
                    cnt_nxt   = '0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                stage_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef CF_FFT_SCHED_ROTATE_EN
    assign bank = cnt[1:0] + stage[1:0];
`else
    assign bank = cnt[1:0];
`endif

    // valid_o qualifies sel_o/addr_o/stage_o/last_o; there is no backpressure,
    // the datapath consumes a sample on every cycle where valid_o is high.
    assign sel_o     = run ? bank : 2'b00;
    assign addr_o    = run ? cnt[LOG_POINTS-1:2] : '0;
    assign stage_o   = stage;
    assign valid_o   = run & enable_i;
    assign last_o    = run & cnt_last;
    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE) & enable_i;
    assign dbg_state = state;

endmodule

// File: tb/tb_cf_fft_1024_8_mux_sched.sv
// Self-checking bench for cf_fft_1024_8_mux_sched: one DUT with stage gaps, one without.
module tb_cf_fft_1024_8_mux_sched;

    localparam int LP    = 4;
    localparam int PTS   = 16;
    localparam int NS_A  = 2;
    localparam int GAP_A = 2;
    localparam int NS_B  = 3;
    localparam int W     = 9;
    localparam int LEN_A = NS_A * PTS + (NS_A - 1) * GAP_A + 1;
    localparam int LEN_B = NS_B * PTS + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, en_a, sync_a;
    logic [1:0]    sel_a, dbg_a;
    logic [LP-3:0] addr_a;
    logic [3:0]    stage_a;
    logic          valid_a, last_a, busy_a, done_a;

    logic          rst_b, en_b, sync_b;
    logic [1:0]    sel_b, dbg_b;
    logic [LP-3:0] addr_b;
    logic [3:0]    stage_b;
    logic          valid_b, last_b, busy_b, done_b;

    cf_fft_1024_8_mux_sched #(.LOG_POINTS(LP), .NUM_STAGES(NS_A), .GAP_CYCLES(GAP_A)) dut_a (
        .clock_c(clk), .reset_i(rst_a), .enable_i(en_a), .sync_i(sync_a),
        .sel_o(sel_a), .addr_o(addr_a), .stage_o(stage_a), .valid_o(valid_a),
        .last_o(last_a), .busy_o(busy_a), .done_o(done_a), .dbg_state(dbg_a)
    );

    cf_fft_1024_8_mux_sched #(.LOG_POINTS(LP), .NUM_STAGES(NS_B), .GAP_CYCLES(0)) dut_b (
        .clock_c(clk), .reset_i(rst_b), .enable_i(en_b), .sync_i(sync_b),
        .sel_o(sel_b), .addr_o(addr_b), .stage_o(stage_b), .valid_o(valid_b),
        .last_o(last_b), .busy_o(busy_b), .done_o(done_b), .dbg_state(dbg_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];
    int frames_a = 0, frames_b = 0;
    int dones_a = 0, dones_b = 0;
    int cyc_a = 0, cyc_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected sample word: {stage, sel, addr, last}.
    function automatic logic [W-1:0] sample(input int s, input int c);
        logic [1:0] sel;
`ifdef CF_FFT_SCHED_ROTATE_EN
        sel = 2'((c + s) % 4);
`else
        sel = 2'(c % 4);
`endif
        return {4'(s), sel, 2'(c / 4), (c == PTS - 1)};
    endfunction

    task automatic start_a();
        @(posedge clk); #1;
        sync_a = 1'b1;
        for (int s = 0; s < NS_A; s++)
            for (int c = 0; c < PTS; c++) exp_q_a.push_back(sample(s, c));
        frames_a++;
        @(posedge clk); #1;
        sync_a = 1'b0;
    endtask

    task automatic start_b();
        @(posedge clk); #1;
        sync_b = 1'b1;
        for (int s = 0; s < NS_B; s++)
            for (int c = 0; c < PTS; c++) exp_q_b.push_back(sample(s, c));
        frames_b++;
        @(posedge clk); #1;
        sync_b = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("a_done_seen", done_a, 1);
    endtask

    task automatic wait_done_b(input int budget);
        int n = 0;
        while (!done_b && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("b_done_seen", done_b, 1);
    endtask

    always @(negedge clk) begin
        if (!rst_a) begin
            if (valid_a) begin
                if (exp_q_a.size() == 0) check("a_extra_valid", 1, 0);
                else check("a_sample", {stage_a, sel_a, addr_a, last_a}, exp_q_a.pop_front());
            end
            if (!en_a) check("a_valid_gated", valid_a, 0);
            if (!busy_a) check("a_idle_outs", {sel_a, addr_a, stage_a, last_a, valid_a, done_a}, 0);
            if (busy_a && en_a) cyc_a++;
            if (done_a) begin
                dones_a++;
                check("a_frame_len", cyc_a, LEN_A);
                check("a_q_empty", exp_q_a.size(), 0);
                cyc_a = 0;
            end
        end else begin
            cyc_a = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            if (valid_b) begin
                if (exp_q_b.size() == 0) check("b_extra_valid", 1, 0);
                else check("b_sample", {stage_b, sel_b, addr_b, last_b}, exp_q_b.pop_front());
            end
            if (busy_b && en_b && !done_b) check("b_contig", valid_b, 1);
            if (!busy_b) check("b_idle_outs", {sel_b, addr_b, stage_b, last_b, valid_b, done_b}, 0);
            if (busy_b && en_b) cyc_b++;
            if (done_b) begin
                dones_b++;
                check("b_frame_len", cyc_b, LEN_B);
                check("b_q_empty", exp_q_b.size(), 0);
                cyc_b = 0;
            end
        end else begin
            cyc_b = 0;
        end
    end

    initial begin
        rst_a = 1'b1; en_a = 1'b1; sync_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b1; sync_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("rst_busy_a", busy_a, 0);
        check("rst_state_a", dbg_a, 0);
        check("rst_busy_b", busy_b, 0);

        // Plain frames on both configurations.
        start_a();
        wait_done_a(200);
        start_b();
        wait_done_b(200);

        // Enable dropped for 5 cycles while cnt = 7 in stage 0.
        start_a();
        repeat (7) @(posedge clk);
        #1;
        en_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("a_hold_busy", busy_a, 1);
        check("a_hold_addr", addr_a, 1);
        en_a = 1'b1;
        wait_done_a(200);

        // sync pulses in RUN and in GAP must be ignored.
        start_a();
        repeat (5) @(posedge clk);
        #1;
        sync_a = 1'b1;
        @(posedge clk); #1;
        sync_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("a_in_gap", dbg_a, 2);
        sync_a = 1'b1;
        @(posedge clk); #1;
        sync_a = 1'b0;
        wait_done_a(200);

        // sync pulse mid-run on the gapless configuration.
        start_b();
        repeat (20) @(posedge clk);
        #1;
        sync_b = 1'b1;
        @(posedge clk); #1;
        sync_b = 1'b0;
        wait_done_b(200);

        // Reset mid-frame at stage 1, cnt 5.
        start_a();
        repeat (23) @(posedge clk);
        #1;
        check("a_pre_rst_stage", stage_a, 1);
        check("a_pre_rst_addr", addr_a, 1);
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("a_mid_rst_outs", {sel_a, addr_a, stage_a, last_a, valid_a, done_a, busy_a}, 0);
        check("a_mid_rst_state", dbg_a, 0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        exp_q_a.delete();
        frames_a--;
        start_a();
        wait_done_a(200);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_done_count", dones_a, frames_a);
        check("b_done_count", dones_b, frames_b);
        check("a_final_q", exp_q_a.size(), 0);
        check("b_final_q", exp_q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
